// File: rtl/spi_ram_arbiter.sv
// Round-robin arbiter between the SPI-slave port (0) and the debug/scrub port (1)
// that turns whole read/write transactions into 10-bit RAM command beats.
module spi_ram_arbiter #(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [7:0]             rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_SIZE+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic [7:0]             ram_dout,
  input  logic                   ram_tx_valid
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_DATA = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4,
    RD_WAIT = 3'd5,
    RESP    = 3'd6
  } state_t;

  state_t                 state_r;
  logic                   prio_r;
  logic                   owner_r;
  logic [ADDR_SIZE-1:0]   addr_r;
  logic [7:0]             wdata_r;
  logic [7:0]             cnt_r;

  logic                   grant_s;
  logic                   we_sel_s;
  logic [ADDR_SIZE-1:0]   addr_sel_s;
  logic [7:0]             wdata_sel_s;

  // Grant selection and the combinational ready towards the winning port
  always_comb begin
    grant_s   = 1'b0;
    req_ready = 2'b00;
    if (state_r == IDLE) begin
      if (req_valid == 2'b11) begin
        grant_s = prio_r;
      end else begin
        grant_s = req_valid[1];
      end
      if (req_valid[grant_s]) begin
        req_ready = grant_s ? 2'b10 : 2'b01;
      end else begin
        req_ready = 2'b00;
      end
    end else begin
      grant_s   = 1'b0;
      req_ready = 2'b00;
    end
  end

  // Fields of the granted port
  always_comb begin
    we_sel_s    = req_we[grant_s];
    addr_sel_s  = grant_s ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE] : req_addr[ADDR_SIZE-1:0];
    wdata_sel_s = grant_s ? req_wdata[15:8] : req_wdata[7:0];
  end

  // Sequencer: beats and responses are loaded on entry to the state that owns them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= IDLE;
      prio_r       <= 1'b0;
      owner_r      <= 1'b0;
      addr_r       <= {ADDR_SIZE{1'b0}};
      wdata_r      <= 8'h00;
      cnt_r        <= 8'h00;
      ram_din      <= {(ADDR_SIZE+2){1'b0}};
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 1'b0;
    end else begin
      ram_din      <= {(ADDR_SIZE+2){1'b0}};
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= 8'h00;
      rsp_err      <= 1'b0;
      case (state_r)
        IDLE: begin
          if ((req_valid & req_ready) != 2'b00) begin
            owner_r      <= grant_s;
            prio_r       <= ~grant_s;
            addr_r       <= addr_sel_s;
            wdata_r      <= wdata_sel_s;
            ram_rx_valid <= 1'b1;
            if (we_sel_s) begin
              state_r <= WR_ADDR;
              ram_din <= {2'b00, addr_sel_s};
            end else begin
              state_r <= RD_ADDR;
              ram_din <= {2'b10, addr_sel_s};
            end
          end
        end
        WR_ADDR: begin
          state_r      <= WR_DATA;
          ram_din      <= {2'b01, ADDR_SIZE'(wdata_r)};
          ram_rx_valid <= 1'b1;
        end
        WR_DATA: begin
          state_r   <= RESP;
          rsp_valid <= owner_r ? 2'b10 : 2'b01;
        end
        RD_ADDR: begin
          state_r      <= RD_DATA;
          ram_din      <= {2'b11, {ADDR_SIZE{1'b0}}};
          ram_rx_valid <= 1'b1;
        end
        RD_DATA: begin
          state_r <= RD_WAIT;
          cnt_r   <= 8'h00;
        end
        RD_WAIT: begin
          // Data arriving on the timeout cycle still counts as a good read
          if (ram_tx_valid) begin
            state_r   <= RESP;
            rsp_valid <= owner_r ? 2'b10 : 2'b01;
            rsp_rdata <= ram_dout;
          end else if (cnt_r == 8'(TIMEOUT - 1)) begin
            state_r   <= RESP;
            rsp_valid <= owner_r ? 2'b10 : 2'b01;
            rsp_err   <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 8'h01;
          end
        end
        RESP: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Self-checking bench for spi_ram_arbiter: directed table, random transactions
// against a transaction-level model, plus alternation and mid-transaction reset sequences.
module tb_spi_ram_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [1:0]  req_we;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic [1:0]  rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_err;
  logic [9:0]  ram_din;
  logic        ram_rx_valid;
  logic [7:0]  ram_dout;
  logic        ram_tx_valid;

  int errors = 0;
  int checks = 0;

  // RAM slave model driven purely by the command beats
  logic [7:0] ram_mem [256];
  logic [7:0] waddr_q;
  logic [7:0] raddr_q;
  // Reference memory and priority, updated from completed transactions only
  logic [7:0] ref_mem [256];
  logic       exp_prio;

  always #5 clk = ~clk;

  spi_ram_arbiter #(.ADDR_SIZE(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_din(ram_din), .ram_rx_valid(ram_rx_valid),
    .ram_dout(ram_dout), .ram_tx_valid(ram_tx_valid)
  );

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'h00;
      waddr_q <= 8'h00;
      raddr_q <= 8'h00;
    end else if (ram_rx_valid) begin
      case (ram_din[9:8])
        2'b00:   waddr_q <= ram_din[7:0];
        2'b01:   ram_mem[waddr_q] <= ram_din[7:0];
        2'b10:   raddr_q <= ram_din[7:0];
        default: ;
      endcase
    end
  end
  assign ram_dout = ram_mem[raddr_q];

  typedef struct {
    logic       port;
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    int         dly;   // 0 = RAM never answers, n = answers n cycles after the read-data beat
    logic       spur;  // drive ram_tx_valid outside RD_WAIT
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clear_ref();
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    exp_prio = 1'b0;
  endtask

  // Whole transaction on one port; starts and ends at a negedge in IDLE
  task automatic run_txn(input logic p, input logic we, input logic [7:0] addr,
                         input logic [7:0] wdata, input int dly, input logic spur,
                         input logic [7:0] exp_rd, input logic exp_err);
    logic [1:0] oh;
    logic       got;
    int         waitc;
    oh = p ? 2'b10 : 2'b01;
    req_we[p] = we;
    if (p) begin
      req_addr[15:8] = addr; req_wdata[15:8] = wdata;
    end else begin
      req_addr[7:0] = addr;  req_wdata[7:0] = wdata;
    end
    req_valid    = oh;
    ram_tx_valid = spur;
    got = 1'b0;
    waitc = 0;
    while (!got && waitc < 8) begin
      #1;
      if (req_ready == oh) got = 1'b1;
      else begin
        @(negedge clk);
        waitc++;
      end
    end
    chk("grant", {31'd0, got}, 32'd1);
    if (!got) begin
      req_valid = 2'b00;
      ram_tx_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 2'b00;
    chk("beat0_valid", {31'd0, ram_rx_valid}, 32'd1);
    chk("beat0_din", {22'd0, ram_din}, {22'd0, (we ? 2'b00 : 2'b10), addr});
    @(negedge clk);
    chk("beat1_valid", {31'd0, ram_rx_valid}, 32'd1);
    chk("beat1_din", {22'd0, ram_din}, {22'd0, (we ? 2'b01 : 2'b11), (we ? wdata : 8'h00)});
    if (!we) begin
      ram_tx_valid = 1'b0;
      for (int i = 0; i < TO; i++) begin
        @(negedge clk);
        chk("wait_no_rsp", {30'd0, rsp_valid}, 32'd0);
        chk("wait_no_beat", {31'd0, ram_rx_valid}, 32'd0);
        ram_tx_valid = (dly == i + 1);
        if (dly == i + 1) break;
      end
    end
    @(negedge clk);
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
    chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, exp_rd});
    chk("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
    ram_tx_valid = spur;
    @(negedge clk);
    chk("rsp_pulse", {30'd0, rsp_valid}, 32'd0);
    ram_tx_valid = 1'b0;
    if (we) ref_mem[addr] = wdata;
    exp_prio = ~p;
  endtask

  vec_t tbl [8];

  initial begin
    logic [1:0] oh_exp;
    logic       nextp;
    logic       lastp;
    int         gcyc;
    int         ngr;
    vec_t       v;

    tbl[0] = '{1'b0, 1'b1, 8'h3C, 8'hA5, 0,  1'b0, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 8'h3C, 8'h00, 1,  1'b0, 8'hA5, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 8'h3C, 8'h00, 0,  1'b0, 8'h00, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 8'h3C, 8'h00, TO, 1'b0, 8'hA5, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 8'h12, 8'h5A, 0,  1'b1, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 1'b0, 8'h12, 8'h00, 3,  1'b1, 8'h5A, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 8'h12, 8'hC3, 0,  1'b1, 8'h00, 1'b0};
    tbl[7] = '{1'b0, 1'b0, 8'h12, 8'h00, 5,  1'b0, 8'hC3, 1'b0};

    rst = 1'b1;
    req_valid = 2'b00;
    req_we = 2'b00;
    req_addr = 16'h0000;
    req_wdata = 16'h0000;
    ram_tx_valid = 1'b0;
    clear_ref();
    repeat (2) @(negedge clk);
    chk("rst_din", {22'd0, ram_din}, 32'd0);
    chk("rst_rx_valid", {31'd0, ram_rx_valid}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      v = tbl[i];
      run_txn(v.port, v.we, v.addr, v.wdata, v.dly, v.spur, v.exp_rdata, v.exp_err);
    end

    // Random transactions predicted by the reference model
    for (int i = 0; i < 30; i++) begin
      logic       rp;
      logic       rwe;
      logic [7:0] ra;
      logic [7:0] rd;
      int         rdl;
      rp  = 1'($urandom_range(0, 1));
      rwe = 1'($urandom_range(0, 1));
      ra  = 8'($urandom_range(0, 7));
      rd  = 8'($urandom);
      rdl = int'($urandom_range(0, TO));
      run_txn(rp, rwe, ra, rd, rdl, 1'($urandom_range(0, 1)),
              (rwe || rdl == 0) ? 8'h00 : ref_mem[ra], !rwe && rdl == 0);
    end

    // Both ports continuously requesting writes: grants must alternate
    req_we = 2'b11;
    req_addr = 16'h2010;
    req_wdata = 16'h2211;
    req_valid = 2'b11;
    nextp = exp_prio;
    lastp = 1'b0;
    gcyc = -10;
    ngr = 0;
    for (int c = 0; c < 16; c++) begin
      #1;
      chk("ready_onehot", $countones(req_ready), (req_ready == 2'b00) ? 32'd0 : 32'd1);
      oh_exp = (c == gcyc + 3) ? (lastp ? 2'b10 : 2'b01) : 2'b00;
      chk("alt_rsp", {30'd0, rsp_valid}, {30'd0, oh_exp});
      if (req_ready != 2'b00) begin
        chk("alt_order", {30'd0, req_ready}, nextp ? 32'd2 : 32'd1);
        lastp = nextp;
        nextp = ~nextp;
        gcyc = c;
        ngr++;
        ref_mem[nextp ? 8'h10 : 8'h20] = nextp ? 8'h11 : 8'h22;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("alt_count", ngr, 32'd4);
    exp_prio = nextp;
    @(negedge clk);
    @(negedge clk);
    run_txn(1'b1, 1'b0, 8'h10, 8'h00, 2, 1'b0, ref_mem[8'h10], 1'b0);
    run_txn(1'b0, 1'b0, 8'h20, 8'h00, 1, 1'b0, ref_mem[8'h20], 1'b0);

    // Asynchronous reset while the write-data beat is on the bus
    req_we = 2'b01;
    req_addr = 16'h0055;
    req_wdata = 16'h0066;
    req_valid = 2'b01;
    #1;
    chk("rst_seq_grant", {30'd0, req_ready}, 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    chk("rst_seq_wd_beat", {22'd0, ram_din}, 32'h166);
    #2 rst = 1'b1;
    #1;
    chk("async_rx_valid", {31'd0, ram_rx_valid}, 32'd0);
    chk("async_din", {22'd0, ram_din}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    clear_ref();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("no_rsp_after_rst", {30'd0, rsp_valid}, 32'd0);
    end
    req_we = 2'b11;
    req_valid = 2'b11;
    #1;
    chk("prio_after_rst", {30'd0, req_ready}, 32'd1);
    req_valid = 2'b00;
    @(negedge clk);
    run_txn(1'b1, 1'b0, 8'h55, 8'h00, 1, 1'b0, ref_mem[8'h55], 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, time %0t limit 2000000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/spi_ram_arbiter.md
Name: spi_ram_arbiter

Overview:
Two-requester round-robin arbiter and command sequencer for the shared single-port SPI-slave RAM. Converts whole read/write transactions into the RAM's 10-bit command beats (din[9:8]: 00 write-addr, 01 write-data, 10 read-addr, 11 read-data). Returns read data (dout on tx_valid) to the owning requester. Port 0 is the SPI-slave side; port 1 is the debug/scrub side.

Parameters:
ADDR_SIZE, 8, RAM address width; must equal the RAM's ADDR_SIZE (din = 2 + ADDR_SIZE bits).
TIMEOUT, 16, maximum cycles in RD_WAIT without ram_tx_valid before an error response; legal range 1..255.

Ports:
clk  input  1  system clock, all flops on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  2  per-requester transaction request; held until accepted
req_ready  output  2  per-requester accept (one-hot or zero); handshake = valid & ready
req_we  input  2  per-requester: 1 = write, 0 = read
req_addr  input  2*ADDR_SIZE  per-requester address ([7:0] = port 0, [15:8] = port 1)
req_wdata  input  16  per-requester write data, same packing
rsp_valid  output  2  one-cycle completion pulse to the owning requester
rsp_rdata  output  8  read data; 0 for writes and errors
rsp_err  output  1  qualifies rsp_valid: 1 = read timeout
ram_din  output  10  RAM command beat {cmd[1:0], payload[7:0]}
ram_rx_valid  output  1  RAM beat strobe
ram_dout  input  8  RAM read data
ram_tx_valid  input  1  RAM read-data valid

Behaviour:
- Reset (async, immediate): state = IDLE; all outputs 0; priority pointer = port 0; timeout counter 0. Any in-flight transaction is dropped and no response is issued.
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA, RD_WAIT, RESP.
- IDLE: req_ready is combinational. It is asserted only to the granted port, and only while in IDLE with that port's req_valid = 1.
  - Grant rule: if both ports request, the port holding priority wins; otherwise the single requester wins.
  - On handshake: capture we, addr, wdata and owner. Move priority to the other port. Go to WR_ADDR if we = 1, else RD_ADDR.
- Beat states: ram_din and ram_rx_valid are registered, loaded on entry, and valid for exactly the state's one cycle.
  - WR_ADDR: {00, addr}, then WR_DATA.
  - WR_DATA: {01, wdata}, then RESP.
  - RD_ADDR: {10, addr}, then RD_DATA.
  - RD_DATA: {11, 8'h00}, then RD_WAIT.
  - In all other states ram_rx_valid = 0 and ram_din = 0.
- RD_WAIT:
  - On entry the counter is cleared; it increments each cycle.
  - If ram_tx_valid = 1: capture ram_dout, set err = 0, go to RESP.
  - Else if counter = TIMEOUT-1: set rdata = 0, err = 1, go to RESP.
  - If ram_tx_valid and the timeout hit occur in the same cycle, data wins and err = 0.
- RESP: rsp_valid[owner] = 1 for one cycle, with rsp_rdata/rsp_err valid that cycle; writes return rdata = 0 and err = 0. Then go to IDLE. No grant is issued during RESP.
- Latency (handshake at edge k):
  - Write: addr beat cycle k+1, data beat k+2, rsp_valid cycle k+3.
  - Read with RAM responding one cycle after the 11 beat: beats k+1 and k+2, tx_valid seen k+3, rsp_valid k+4.
  - Next grant possible at the edge ending the IDLE cycle that follows RESP.
- ram_tx_valid outside RD_WAIT is ignored.
- Stable requests on both ports strictly alternate 0,1,0,1.

Test Plan:
- Reset, then port 0 writes addr 0x3C data 0xA5 -> ram_din 0x03C then 0x13C...0x1A5. Correction: ram_din 0x03C then 0x1A5 on consecutive cycles, ram_rx_valid high for both; rsp_valid = 2'b01 at k+3; rsp_err = 0.
- Port 1 reads 0x3C, RAM model returns 0xA5 -> ram_din 0x23C then 0x300; rsp_valid = 2'b10 with rsp_rdata = 0xA5, rsp_err = 0.
- Both ports hold write requests for 4 transactions -> grants 0,1,0,1; req_ready never has two bits set.
- Read with RAM model never asserting tx_valid, TIMEOUT = 16 -> exactly 16 RD_WAIT cycles, then rsp_valid with rsp_err = 1 and rsp_rdata = 0x00.
- Assert rst during WR_DATA -> ram_rx_valid and ram_din go to 0 without a clock edge; no rsp_valid; the next request starts a fresh transaction with priority at port 0.
- Spurious ram_tx_valid in IDLE and WR_DATA, plus tx_valid coinciding with the timeout cycle -> no stray response; the coinciding case returns data with rsp_err = 0.
